// File: rtl/icb_multi_master_arb_if.sv
// ICB master port bundle between the accelerator arbiter and the system bus.
// The master modport is the arbiter side; the slave modport is the bus/memory side.
interface icb_multi_master_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  acc_icb_cmd_valid;
    logic                  acc_icb_cmd_ready;
    logic [ADDR_W-1:0]     acc_icb_cmd_addr;
    logic                  acc_icb_cmd_read;
    logic [DATA_W-1:0]     acc_icb_cmd_wdata;
    logic [DATA_W/8-1:0]   acc_icb_cmd_wmask;
    logic                  acc_icb_rsp_valid;
    logic                  acc_icb_rsp_ready;
    logic                  acc_icb_rsp_err;
    logic [DATA_W-1:0]     acc_icb_rsp_rdata;

    modport master (
        output acc_icb_cmd_valid, acc_icb_cmd_addr, acc_icb_cmd_read,
               acc_icb_cmd_wdata, acc_icb_cmd_wmask, acc_icb_rsp_ready,
        input  acc_icb_cmd_ready, acc_icb_rsp_valid, acc_icb_rsp_err, acc_icb_rsp_rdata
    );

    modport slave (
        input  acc_icb_cmd_valid, acc_icb_cmd_addr, acc_icb_cmd_read,
               acc_icb_cmd_wdata, acc_icb_cmd_wmask, acc_icb_rsp_ready,
        output acc_icb_cmd_ready, acc_icb_rsp_valid, acc_icb_rsp_err, acc_icb_rsp_rdata
    );
endinterface

// File: rtl/icb_multi_master_arb.sv
// Per-command arbiter merging NUM_RD_CH read BIUs and one write BIU onto one ICB port,
// with an in-order tracker FIFO routing responses. Define ICB_ARB_RR_EN for round-robin reads.
module icb_multi_master_arb #(
    parameter int NUM_RD_CH = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int OT_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD_CH-1:0]          i_rd_req_valid,
    output logic [NUM_RD_CH-1:0]          o_rd_req_ready,
    input  logic [NUM_RD_CH*ADDR_W-1:0]   i_rd_req_addr,
    output logic [NUM_RD_CH-1:0]          o_rd_rsp_valid,
    input  logic [NUM_RD_CH-1:0]          i_rd_rsp_ready,
    output logic [ADDR_W-1:0]             o_rd_rsp_addr,
    output logic [DATA_W-1:0]             o_rd_rsp_data,
    output logic                          o_rd_rsp_err,
    input  logic                          i_wr_req_valid,
    output logic                          o_wr_req_ready,
    input  logic [ADDR_W-1:0]             i_wr_req_addr,
    input  logic [DATA_W-1:0]             i_wr_req_data,
    input  logic [DATA_W/8-1:0]           i_wr_req_mask,
    output logic                          o_wr_done,
    output logic                          o_wr_err,
    output logic                          o_stray_rsp_err,
    icb_multi_master_arb_if.master        acc
);
    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1;

    typedef enum logic [0:0] {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_lock_wr;
    logic [CW-1:0]       r_lock_ch;
    logic [PW:0]         r_wptr;
    logic [PW:0]         r_rptr;
    logic                r_ot_wr   [OT_DEPTH];
    logic [CW-1:0]       r_ot_ch   [OT_DEPTH];
    logic [ADDR_W-1:0]   r_ot_addr [OT_DEPTH];
    logic                r_stray;

    logic                w_full;
    logic                w_empty;
    logic                w_any_rd;
    logic [CW-1:0]       w_rd_win;
    logic                w_sel_wr;
    logic [CW-1:0]       w_sel_ch;
    logic                w_cmd_valid;
    logic                w_cmd_hs;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_head_wr;
    logic [CW-1:0]       w_head_ch;
    logic [ADDR_W-1:0]   w_head_addr;
    logic                w_head_rdy;
    logic                w_rsp_ready;
    logic                w_rd_rsp_act;
    logic                w_pop;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_any_rd = |i_rd_req_valid;

    function automatic logic [CW-1:0] pick_fixed(input logic [NUM_RD_CH-1:0] v);
        pick_fixed = '0;
        for (int i = NUM_RD_CH - 1; i >= 0; i--) begin
            pick_fixed = v[i] ? CW'(i) : pick_fixed;
        end
    endfunction

`ifdef ICB_ARB_RR_EN
    logic [CW-1:0] r_rr_ptr;

    // Search starts at the channel after the last granted read.
    function automatic logic [CW-1:0] pick_rr(input logic [NUM_RD_CH-1:0] v, input logic [CW-1:0] ptr);
        int   idx;
        logic found;
        pick_rr = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_RD_CH; i++) begin
            idx = int'(ptr) + i;
            idx = (idx >= NUM_RD_CH) ? idx - NUM_RD_CH : idx;
            if (v[idx] && !found) begin
                pick_rr = CW'(idx);
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    assign w_rd_win = pick_rr(i_rd_req_valid, r_rr_ptr);

    // Round-robin pointer: last granted read + 1, moved only on a read handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_cmd_hs && !w_sel_wr) begin
            r_rr_ptr <= (w_sel_ch == CW'(NUM_RD_CH - 1)) ? '0 : w_sel_ch + CW'(1);
        end
    end
`else
    assign w_rd_win = pick_fixed(i_rd_req_valid);
`endif

    // Grant FSM: combinational winner when unlocked, frozen winner while stalled.
    always_comb begin
        w_next_state = r_state;
        w_sel_wr     = 1'b0;
        w_sel_ch     = '0;
        w_cmd_valid  = 1'b0;
        case (r_state)
            ST_LOCKED: begin
                w_sel_wr    = r_lock_wr;
                w_sel_ch    = r_lock_ch;
                w_cmd_valid = 1'b1;
                if (acc.acc_icb_cmd_ready) w_next_state = ST_UNLOCKED;
                else                       w_next_state = ST_LOCKED;
            end
            ST_UNLOCKED: begin
                w_sel_wr    = i_wr_req_valid;
                w_sel_ch    = w_rd_win;
                w_cmd_valid = (i_wr_req_valid || w_any_rd) && !w_full;
                if (w_cmd_valid && !acc.acc_icb_cmd_ready) w_next_state = ST_LOCKED;
                else                                       w_next_state = ST_UNLOCKED;
            end
            default: begin
                w_next_state = ST_UNLOCKED;
            end
        endcase
    end

    // Grant state and locked winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_UNLOCKED;
            r_lock_wr <= 1'b0;
            r_lock_ch <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_UNLOCKED && w_next_state == ST_LOCKED) begin
                r_lock_wr <= w_sel_wr;
                r_lock_ch <= w_sel_ch;
            end
        end
    end

    assign w_cmd_hs = w_cmd_valid && acc.acc_icb_cmd_ready;

    // Command channel drive and zero-latency ready back to the winning requester.
    always_comb begin
        w_rd_addr = '0;
        for (int k = 0; k < NUM_RD_CH; k++) begin
            w_rd_addr = (w_sel_ch == CW'(k)) ? i_rd_req_addr[k*ADDR_W +: ADDR_W] : w_rd_addr;
        end
        acc.acc_icb_cmd_valid = w_cmd_valid;
        acc.acc_icb_cmd_read  = w_cmd_valid && !w_sel_wr;
        if (!w_cmd_valid) begin
            acc.acc_icb_cmd_addr  = '0;
            acc.acc_icb_cmd_wdata = '0;
            acc.acc_icb_cmd_wmask = '0;
        end else if (w_sel_wr) begin
            acc.acc_icb_cmd_addr  = i_wr_req_addr;
            acc.acc_icb_cmd_wdata = i_wr_req_data;
            acc.acc_icb_cmd_wmask = i_wr_req_mask;
        end else begin
            acc.acc_icb_cmd_addr  = w_rd_addr;
            acc.acc_icb_cmd_wdata = '0;
            acc.acc_icb_cmd_wmask = '0;
        end
        o_wr_req_ready = w_cmd_hs && w_sel_wr;
        for (int k = 0; k < NUM_RD_CH; k++) begin
            o_rd_req_ready[k] = w_cmd_hs && !w_sel_wr && (w_sel_ch == CW'(k));
        end
    end

    assign w_head_wr   = r_ot_wr[r_rptr[PW-1:0]];
    assign w_head_ch   = r_ot_ch[r_rptr[PW-1:0]];
    assign w_head_addr = r_ot_addr[r_rptr[PW-1:0]];

    // Response routing to the channel at the tracker head.
    always_comb begin
        w_head_rdy = 1'b0;
        for (int k = 0; k < NUM_RD_CH; k++) begin
            w_head_rdy = (w_head_ch == CW'(k)) ? i_rd_rsp_ready[k] : w_head_rdy;
        end
        w_rsp_ready           = !w_empty && (w_head_wr || w_head_rdy);
        acc.acc_icb_rsp_ready = w_rsp_ready;
        w_rd_rsp_act          = !w_empty && !w_head_wr && acc.acc_icb_rsp_valid;
        for (int k = 0; k < NUM_RD_CH; k++) begin
            o_rd_rsp_valid[k] = w_rd_rsp_act && (w_head_ch == CW'(k));
        end
        o_rd_rsp_data = w_rd_rsp_act ? acc.acc_icb_rsp_rdata : '0;
        o_rd_rsp_err  = w_rd_rsp_act && acc.acc_icb_rsp_err;
        o_rd_rsp_addr = w_rd_rsp_act ? w_head_addr : '0;
        o_wr_done     = !w_empty && w_head_wr && acc.acc_icb_rsp_valid;
        o_wr_err      = o_wr_done && acc.acc_icb_rsp_err;
        w_pop         = acc.acc_icb_rsp_valid && w_rsp_ready;
    end

    // Outstanding-transaction tracker; push on command handshake, pop on response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < OT_DEPTH; i++) begin
                r_ot_wr[i]   <= 1'b0;
                r_ot_ch[i]   <= '0;
                r_ot_addr[i] <= '0;
            end
        end else begin
            if (w_cmd_hs) begin
                r_ot_wr[r_wptr[PW-1:0]]   <= w_sel_wr;
                r_ot_ch[r_wptr[PW-1:0]]   <= w_sel_ch;
                r_ot_addr[r_wptr[PW-1:0]] <= acc.acc_icb_cmd_addr;
                r_wptr                    <= r_wptr + {{PW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stray <= 1'b0;
        end else if (acc.acc_icb_rsp_valid && w_empty) begin
            r_stray <= 1'b1;
        end
    end

    assign o_stray_rsp_err = r_stray;
endmodule
